// File: rtl/dense_to_coo.sv
// Dense M x N matrix to COO entry stream converter.
// A start in IDLE snapshots the matrix and a nonzero mask. Nonzero entries
// are then emitted in row-major order over a valid/ready handshake, with at
// most MAX_LIST_SIZE entries per conversion. Any excess nonzeros are dropped
// and reported through the overflow flag.
module dense_to_coo #(
  parameter int DATA_SIZE     = 16,
  parameter int M             = 4,
  parameter int N             = 4,
  parameter int MAX_LIST_SIZE = 30,
  localparam int RW = (M > 1) ? $clog2(M) : 1,
  localparam int CLW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(MAX_LIST_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [M*N*DATA_SIZE-1:0] dense_in,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RW-1:0]            out_row,
  output logic [CLW-1:0]           out_col,
  output logic [DATA_SIZE-1:0]     out_val,
  output logic                     out_last,
  output logic                     done,
  output logic [CW-1:0]            nnz_count,
  output logic                     overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [M*N*DATA_SIZE-1:0]   snap_q, snap_d;
  logic [M*N-1:0]             mask_q, mask_d;
  logic                       out_valid_q, out_valid_d;
  logic [RW-1:0]              out_row_q, out_row_d;
  logic [CLW-1:0]             out_col_q, out_col_d;
  logic [DATA_SIZE-1:0]       out_val_q, out_val_d;
  logic                       out_last_q, out_last_d;
  logic                       done_q, done_d;
  logic [CW-1:0]              nnz_q, nnz_d;
  logic                       overflow_q, overflow_d;

  // Lowest pending nonzero and the mask that remains once it is taken.
  logic                       hit;
  logic [RW-1:0]              hit_row;
  logic [CLW-1:0]             hit_col;
  logic [DATA_SIZE-1:0]       hit_val;
  logic [M*N-1:0]             rest_mask;
  logic                       load;

  // Priority-encode the mask; nested row/column loops give the indices
  // directly so no divider is needed.
  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment;
    // a path that leaves one unassigned would infer a latch.
    hit       = 1'b0;
    hit_row   = '0;
    hit_col   = '0;
    hit_val   = '0;
    rest_mask = mask_q;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!hit && mask_q[r*N+c]) begin
          hit                = 1'b1;
          hit_row            = RW'(r);
          hit_col            = CLW'(c);
          hit_val            = snap_q[(r*N+c)*DATA_SIZE +: DATA_SIZE];
          rest_mask[r*N+c]   = 1'b0;
        end
      end
    end
  end

  // Next-state and next-output computation for the conversion FSM.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_val_d   = out_val_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    nnz_d       = nnz_q;
    overflow_d  = overflow_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = dense_in;
          for (int i = 0; i < M*N; i++) begin
            mask_d[i] = |dense_in[i*DATA_SIZE +: DATA_SIZE];
          end
          nnz_d      = '0;
          overflow_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          load    = 1'b1;
          state_d = EMIT;
        end else begin
          done_d     = 1'b1;
          overflow_d = |mask_q;
          state_d    = DONE;
        end
      end
      EMIT: begin
        if (out_valid_q && out_ready) begin
          nnz_d = nnz_q + CW'(1);
          if (!out_last_q) begin
            // A non-last entry guarantees the mask still holds a nonzero.
            load = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            overflow_d  = |mask_q;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The entry being loaded is last if nothing remains after it, or if it
    // fills the list (it will be entry number nnz_d + 1).
    if (load) begin
      out_valid_d = 1'b1;
      out_row_d   = hit_row;
      out_col_d   = hit_col;
      out_val_d   = hit_val;
      mask_d      = rest_mask;
      out_last_d  = ~|rest_mask || (int'(nnz_d) + 1 == MAX_LIST_SIZE);
    end
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: the snapshot and mask are cleared with the control state so a
      // stale matrix can never leak into a later conversion.
      snap_q      <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_val_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      nnz_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_val_q   <= out_val_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      nnz_q       <= nnz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_val   = out_val_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign nnz_count = nnz_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dense_to_coo.sv
// Scoreboard bench for dense_to_coo: a row-major reference model queues the
// expected entries and completion status, and a negedge monitor compares
// every accepted beat and done pulse against those queues.
module tb_dense_to_coo;

  localparam int DS  = 16;
  localparam int M   = 4;
  localparam int N   = 4;
  localparam int MAX = 10;
  localparam int W   = M * N * DS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  dense_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic [DS-1:0] out_val;
  logic          out_last;
  logic          done;
  logic [3:0]    nnz_count;
  logic          overflow;

  dense_to_coo #(.DATA_SIZE(DS), .M(M), .N(N), .MAX_LIST_SIZE(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dense_in  (dense_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_val   (out_val),
    .out_last  (out_last),
    .done      (done),
    .nnz_count (nnz_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    logic [15:0] val;
    bit          last;
  } beat_t;

  typedef struct {
    int nnz;
    bit ovf;
  } fin_t;

  beat_t exp_q[$];
  fin_t  fin_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the matrix in row-major order, keep the first MAX
  // nonzeros, flag the final kept one, and note whether any were dropped.
  function automatic int push_expected(input logic [W-1:0] mat);
    int    emitted = 0;
    int    total   = 0;
    beat_t b;
    fin_t  f;
    logic [15:0] e;
    for (int i = 0; i < M*N; i++) begin
      e = mat[i*DS +: DS];
      if (e != 0) begin
        total++;
        if (emitted < MAX) begin
          b.row  = i / N;
          b.col  = i % N;
          b.val  = e;
          b.last = 1'b0;
          exp_q.push_back(b);
          emitted++;
        end
      end
    end
    if (emitted > 0) exp_q[exp_q.size()-1].last = 1'b1;
    f.nnz = emitted;
    f.ovf = (total > MAX);
    fin_q.push_back(f);
    return emitted;
  endfunction

  function automatic logic [W-1:0] rand_mat(input int pct);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < M*N; i++) begin
      if ($urandom_range(0, 99) < pct) m[i*DS +: DS] = 16'($urandom_range(1, 65535));
    end
    return m;
  endfunction

  // Monitor: compare accepted beats, hold stability under stall, and done.
  bit          stalled = 1'b0;
  logic [20:0] held;
  always @(negedge clk) begin
    beat_t e;
    fin_t  f;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'({out_row, out_col, out_val, out_last}), int'(held));
      end
      stalled = 1'b0;
      if (out_valid) begin
        check("val_nonzero", int'(out_val != 0), 1);
        if (out_ready) begin
          check("beat_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_row", int'(out_row), e.row);
            check("beat_col", int'(out_col), e.col);
            check("beat_val", int'(out_val), int'(e.val));
            check("beat_last", int'(out_last), int'(e.last));
          end
        end else begin
          stalled = 1'b1;
          held    = {out_row, out_col, out_val, out_last};
        end
      end
      if (done) begin
        check("done_expected", int'(fin_q.size() > 0), 1);
        if (fin_q.size() > 0) begin
          f = fin_q.pop_front();
          check("done_nnz", int'(nnz_count), f.nnz);
          check("done_overflow", int'(overflow), int'(f.ovf));
          check("beats_drained", exp_q.size(), 0);
        end
      end
    end
  end

  // One conversion. ready_mode: 0 always ready, 1 random, 2 pattern 0,0,1.
  // With disturb set, start is re-pulsed and dense_in scrambled mid-stream.
  task automatic run_conv(input logic [W-1:0] mat, input int ready_mode, input bit disturb);
    int nexp;
    int cyc      = 0;
    int first_v  = -1;
    int done_cyc = -1;
    @(posedge clk);
    #1;
    dense_in  = mat;
    start     = 1'b1;
    out_ready = 1'b0;
    nexp      = push_expected(mat);
    @(posedge clk);  // start accepted here (edge 0)
    #1;
    start = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ((cyc - 1) % 3 == 2);
      endcase
      if (disturb && cyc == 2) begin
        start    = 1'b1;
        dense_in = rand_mat(70);
      end
      if (disturb && cyc == 3) start = 1'b0;
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) done_cyc = cyc;
    end
    check("done_seen", int'(done_cyc >= 0), 1);
    if (ready_mode == 0) begin
      check("first_valid_cycle", first_v, (nexp > 0) ? 1 : -1);
      check("done_cycle", done_cyc, nexp + 1);
    end
    if (ready_mode == 2 && nexp == 1) check("stall_done_cycle", done_cyc, 4);
    check("busy_in_done", int'(busy), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    check("nnz_held", int'(nnz_count), nexp);
  endtask

  logic [W-1:0] mat;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dense_in  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_nnz", int'(nnz_count), 0);
    check("rst_overflow", int'(overflow), 0);

    // Identity with 1..4 on the diagonal, always ready.
    mat = '0;
    for (int i = 0; i < 4; i++) mat[(i*N+i)*DS +: DS] = 16'(i + 1);
    run_conv(mat, 0, 1'b0);

    // All-zero matrix.
    run_conv('0, 0, 1'b0);

    // Every element 0xFFFF: list capped, overflow raised.
    mat = '1;
    run_conv(mat, 0, 1'b0);
    check("cap_overflow", int'(overflow), 1);

    // Single -5 at (3,2) with ready pattern 0,0,1.
    mat = '0;
    mat[(3*N+2)*DS +: DS] = -16'sd5;
    run_conv(mat, 2, 1'b0);

    // Start re-pulsed and dense_in changed during the identity stream.
    mat = '0;
    for (int i = 0; i < 4; i++) mat[(i*N+i)*DS +: DS] = 16'(i + 1);
    run_conv(mat, 0, 1'b1);

    // Reset after two of five beats have been accepted.
    mat = '0;
    mat[0*DS +: DS]  = 16'h0011;
    mat[3*DS +: DS]  = 16'h0022;
    mat[5*DS +: DS]  = 16'h8000;
    mat[10*DS +: DS] = 16'h0044;
    mat[15*DS +: DS] = 16'hfff0;
    @(posedge clk);
    #1;
    dense_in  = mat;
    start     = 1'b1;
    out_ready = 1'b1;
    void'(push_expected(mat));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_nnz", int'(nnz_count), 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    fin_q.delete();
    out_ready = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_nnz", int'(nnz_count), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(posedge clk);
    run_conv(mat, 0, 1'b0);

    // Randomized matrices, densities and ready behaviour.
    for (int t = 0; t < 40; t++) begin
      run_conv(rand_mat($urandom_range(0, 100)), $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
